// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: control codes, ALUOp and
// funct encodings, counter width and FSM state type.
package alu_ctrl_pkg;

  localparam int unsigned CODE_W  = 4;
  localparam int unsigned FUNCT_W = 10;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned CNT_W   = 4;

  localparam logic [CODE_W-1:0] CODE_ADD     = 4'b0001;
  localparam logic [CODE_W-1:0] CODE_SUB     = 4'b0010;
  localparam logic [CODE_W-1:0] CODE_AND     = 4'b0011;
  localparam logic [CODE_W-1:0] CODE_OR      = 4'b0100;
  localparam logic [CODE_W-1:0] CODE_MUL     = 4'b0110;
  localparam logic [CODE_W-1:0] CODE_RELU    = 4'b0111;
  localparam logic [CODE_W-1:0] CODE_MAXPOOL = 4'b1000;
  localparam logic [CODE_W-1:0] CODE_FC      = 4'b1001;

  localparam logic [ALUOP_W-1:0] ALUOP_ADDI    = 2'b11;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE   = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_BRANCH  = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_DEFAULT = 2'b00;

  // funct7 in [9:3], funct3 in [2:0]
  localparam logic [FUNCT_W-1:0] FUNCT_ADD     = 10'b0000000000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB     = 10'b0100000000;
  localparam logic [FUNCT_W-1:0] FUNCT_AND     = 10'b0000000111;
  localparam logic [FUNCT_W-1:0] FUNCT_OR      = 10'b0000000110;
  localparam logic [FUNCT_W-1:0] FUNCT_MUL     = 10'b0000001000;
  localparam logic [FUNCT_W-1:0] FUNCT_RELU    = 10'b1000000111;
  localparam logic [FUNCT_W-1:0] FUNCT_MAXPOOL = 10'b1100000111;
  localparam logic [FUNCT_W-1:0] FUNCT_FC      = 10'b1110000111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct decode into a 4-bit control code, with flags for
// multi-cycle operations and unknown encodings.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic               ext_en,
  output logic [CODE_W-1:0]  code,
  output logic               is_multi,
  output logic               illegal
);

  always_comb begin
    code     = CODE_ADD;
    is_multi = 1'b0;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_ADDI, ALUOP_DEFAULT: code = CODE_ADD;
      ALUOP_BRANCH:              code = CODE_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: code = CODE_ADD;
          FUNCT_SUB: code = CODE_SUB;
          FUNCT_AND: code = CODE_AND;
          FUNCT_OR:  code = CODE_OR;
          FUNCT_MUL: begin
            code     = CODE_MUL;
            is_multi = 1'b1;
          end
          // CNN extensions fall back to an illegal add when disabled
          FUNCT_RELU: begin
            code     = ext_en ? CODE_RELU : CODE_ADD;
            is_multi = ext_en;
            illegal  = !ext_en;
          end
          FUNCT_MAXPOOL: begin
            code     = ext_en ? CODE_MAXPOOL : CODE_ADD;
            is_multi = ext_en;
            illegal  = !ext_en;
          end
          FUNCT_FC: begin
            code     = ext_en ? CODE_FC : CODE_ADD;
            is_multi = ext_en;
            illegal  = !ext_en;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: code = CODE_ADD;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: issues decoded ALU control codes and tracks
// multi-cycle MUL/CNN operations with a latency down-counter.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned LAT_MUL = 3,
  parameter int unsigned LAT_CNN = 4,
  parameter bit          EXT_EN  = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               valid_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic [CODE_W-1:0]  ALUCtrl_o,
  output logic               start_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               stall_o,
  output logic               illegal_o
);

  if (LAT_MUL < 2 || LAT_MUL > 15) begin : g_lat_mul_range
    $error("alu_ctrl_seq: LAT_MUL must be in 2..15");
  end
  if (LAT_CNN < 2 || LAT_CNN > 15) begin : g_lat_cnn_range
    $error("alu_ctrl_seq: LAT_CNN must be in 2..15");
  end

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(LAT_MUL - 1);
  localparam logic [CNT_W-1:0] CNN_LOAD = CNT_W'(LAT_CNN - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CODE_W-1:0]  dec_code;
  logic               dec_multi;
  logic               dec_illegal;
  logic               accept_c;

  alu_ctrl_dec u_dec (
    .funct    (funct_i),
    .alu_op   (ALUOp_i),
    .ext_en   (EXT_EN),
    .code     (dec_code),
    .is_multi (dec_multi),
    .illegal  (dec_illegal)
  );

  // flush wins over a simultaneous request
  assign accept_c = valid_i & ready_o & ~flush_i;
  assign stall_o  = valid_i & ~ready_o;

  // FSM, latency counter and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ALUCtrl_o <= CODE_ADD;
      start_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      illegal_o <= 1'b0;
      ready_o   <= 1'b1;
    end else begin
      start_o   <= 1'b0;
      done_o    <= 1'b0;
      illegal_o <= 1'b0;
      if (flush_i) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        ALUCtrl_o <= CODE_ADD;
        busy_o    <= 1'b0;
        ready_o   <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (accept_c) begin
              ALUCtrl_o <= dec_code;
              start_o   <= 1'b1;
              illegal_o <= dec_illegal;
              if (dec_multi) begin
                state_q <= ST_BUSY;
                cnt_q   <= (dec_code == CODE_MUL) ? MUL_LOAD : CNN_LOAD;
                busy_o  <= 1'b1;
                ready_o <= 1'b0;
              end else begin
                done_o  <= 1'b1;
              end
            end
          end
          ST_BUSY: begin
            // last decrement lands in the done cycle, which is already IDLE
            if (cnt_q == CNT_W'(1)) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              busy_o  <= 1'b0;
              ready_o <= 1'b1;
              done_o  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq: scoreboard of expected issues,
// checked by immediate assertions as each operation appears at the outputs.
module tb_alu_ctrl_seq;

  localparam int unsigned TB_LAT_MUL = 3;
  localparam int unsigned TB_LAT_CNN = 4;

  typedef struct {
    logic [3:0] code;
    logic       ill;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid = 1'b0;
  logic [9:0] funct = '0;
  logic [1:0] aluop = '0;
  logic       flush = 1'b0;

  logic       ready, start, busy, done, stall, illegal;
  logic [3:0] ctrl;
  logic       ready0, start0, busy0, done0, stall0, illegal0;
  logic [3:0] ctrl0;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  alu_ctrl_seq #(.LAT_MUL(TB_LAT_MUL), .LAT_CNN(TB_LAT_CNN), .EXT_EN(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .funct_i(funct), .ALUOp_i(aluop),
    .flush_i(flush), .ready_o(ready), .ALUCtrl_o(ctrl), .start_o(start), .busy_o(busy),
    .done_o(done), .stall_o(stall), .illegal_o(illegal)
  );

  alu_ctrl_seq #(.LAT_MUL(TB_LAT_MUL), .LAT_CNN(TB_LAT_CNN), .EXT_EN(1'b0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .funct_i(funct), .ALUOp_i(aluop),
    .flush_i(flush), .ready_o(ready0), .ALUCtrl_o(ctrl0), .start_o(start0), .busy_o(busy0),
    .done_o(done0), .stall_o(stall0), .illegal_o(illegal0)
  );

  // Reference decode table
  function automatic exp_t model(input logic [9:0] f, input logic [1:0] op, input bit ext);
    exp_t e;
    e.code = 4'b0001; e.ill = 1'b0; e.lat = 1;
    if (op == 2'b01) e.code = 4'b0010;
    else if (op == 2'b10) begin
      case (f)
        10'b0000000000: e.code = 4'b0001;
        10'b0100000000: e.code = 4'b0010;
        10'b0000000111: e.code = 4'b0011;
        10'b0000000110: e.code = 4'b0100;
        10'b0000001000: begin e.code = 4'b0110; e.lat = TB_LAT_MUL; end
        10'b1000000111: if (ext) begin e.code = 4'b0111; e.lat = TB_LAT_CNN; end else e.ill = 1'b1;
        10'b1100000111: if (ext) begin e.code = 4'b1000; e.lat = TB_LAT_CNN; end else e.ill = 1'b1;
        10'b1110000111: if (ext) begin e.code = 4'b1001; e.lat = TB_LAT_CNN; end else e.ill = 1'b1;
        default: e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] f, input logic [1:0] op);
    funct = f;
    aluop = op;
    valid = 1'b1;
    sbq.push_back(model(f, op, 1'b1));
  endtask

  // Called in the cycle after acceptance; follows the op until its done cycle
  task automatic check_issue(input string tag);
    exp_t e;
    int n;
    #1;
    if (sbq.size() == 0) begin
      chk({tag, " sb_empty"}, 32'(sbq.size()), 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk({tag, " code"}, 32'(ctrl), 32'(e.code));
    chk({tag, " start"}, 32'(start), 32'd1);
    chk({tag, " illegal"}, 32'(illegal), 32'(e.ill));
    n = 1;
    while (!done && n < 20) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " ready_low"}, 32'(ready), 32'd0);
      chk({tag, " stall"}, 32'(stall), 32'(valid));
      chk({tag, " code_hold"}, 32'(ctrl), 32'(e.code));
      step();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(e.lat));
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " ready_done"}, 32'(ready), 32'd1);
    chk({tag, " busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [9:0] f_tab [8];
    logic [1:0] op_tab [8];
    exp_t e;

    f_tab  = '{10'b0000000000, 10'b0100000000, 10'b0000000111, 10'b1111111111,
               10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000110};
    op_tab = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10};

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst ctrl", 32'(ctrl), 32'h1);
    chk("rst start", 32'(start), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst ready", 32'(ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("post_rst ready", 32'(ready), 32'd1);

    // Sub after reset
    drive(10'b0100000000, 2'b10);
    step();
    valid = 1'b0;
    check_issue("sub");

    // Back-to-back single-cycle ops, valid held high
    for (int i = 0; i < 8; i++) begin
      drive(f_tab[i], op_tab[i]);
      step();
      check_issue($sformatf("single%0d", i));
    end
    valid = 1'b0;
    step();
    chk("idle ctrl_hold", 32'(ctrl), 32'h4);
    chk("idle start", 32'(start), 32'd0);
    chk("idle done", 32'(done), 32'd0);

    // Mul with a pending add stalling, then chained
    drive(10'b0000001000, 2'b10);
    step();
    drive(10'b0000000000, 2'b10);
    check_issue("mul");
    step();
    valid = 1'b0;
    check_issue("add_after_mul");

    // fc then maxpool chained into the fc done cycle
    drive(10'b1110000111, 2'b10);
    step();
    drive(10'b1100000111, 2'b10);
    check_issue("fc");
    step();
    valid = 1'b0;
    check_issue("maxpool");

    // relu: legal on full build, illegal add on EXT_EN=0 build
    drive(10'b1000000111, 2'b10);
    step();
    valid = 1'b0;
    #1;
    e = model(10'b1000000111, 2'b10, 1'b0);
    chk("ext0 ctrl", 32'(ctrl0), 32'(e.code));
    chk("ext0 illegal", 32'(illegal0), 32'(e.ill));
    chk("ext0 done", 32'(done0), 32'd1);
    chk("ext0 start", 32'(start0), 32'd1);
    check_issue("relu");
    step();
    chk("ext0 illegal_pulse", 32'(illegal0), 32'd0);

    // Flush during mul, colliding with a new request
    drive(10'b0000001000, 2'b10);
    step();
    valid = 1'b0;
    #1;
    e = sbq.pop_front();
    chk("flush pre code", 32'(ctrl), 32'(e.code));
    chk("flush pre busy", 32'(busy), 32'd1);
    flush = 1'b1;
    valid = 1'b1;
    funct = 10'b0100000000;
    aluop = 2'b10;
    step();
    flush = 1'b0;
    valid = 1'b0;
    chk("flush ctrl", 32'(ctrl), 32'h1);
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush ready", 32'(ready), 32'd1);
    chk("flush done", 32'(done), 32'd0);
    chk("flush start", 32'(start), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flush no_done", 32'(done), 32'd0);
      chk("flush no_start", 32'(start), 32'd0);
    end

    // Async reset during BUSY
    drive(10'b1110000111, 2'b10);
    step();
    valid = 1'b0;
    #1;
    e = sbq.pop_front();
    chk("rstbusy pre code", 32'(ctrl), 32'(e.code));
    chk("rstbusy pre busy", 32'(busy), 32'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rstbusy ctrl", 32'(ctrl), 32'h1);
    chk("rstbusy busy", 32'(busy), 32'd0);
    chk("rstbusy start", 32'(start), 32'd0);
    chk("rstbusy done", 32'(done), 32'd0);
    chk("rstbusy illegal", 32'(illegal), 32'd0);
    chk("rstbusy stall", 32'(stall), 32'd0);
    chk("rstbusy ready", 32'(ready), 32'd1);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("rstbusy release ready", 32'(ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("rstbusy no_done", 32'(done), 32'd0);
      step();
    end

    // Operation after reset recovery
    drive(10'b0000000111, 2'b10);
    step();
    valid = 1'b0;
    check_issue("and_after_rst");

    chk("sb drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 The block SHALL have parameter LAT_MUL, default 3, giving MUL latency in cycles; legal range 2..15.
REQ-002 The block SHALL have parameter LAT_CNN, default 4, giving Relu/MaxPool/FC latency in cycles; legal range 2..15.
REQ-003 The block SHALL have parameter EXT_EN, default 1; when 1, the Relu/MaxPool/FC decodes are enabled.
REQ-004 The block SHALL have the following ports, clock and reset first:
- clk_i  in  1  sole clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- valid_i  in  1  request valid.
- funct_i  in  10  funct7[9:3] concatenated with funct3[2:0].
- ALUOp_i  in  2  11 = addi, 10 = R-type, 01 = branch, 00 = default.
- flush_i  in  1  abort the in-flight operation.
- ready_o  out  1  block accepts a request this cycle.
- ALUCtrl_o  out  4  registered ALU control code.
- start_o  out  1  one-cycle pulse: operation issued.
- busy_o  out  1  multi-cycle operation in flight.
- done_o  out  1  one-cycle pulse: result valid this cycle.
- stall_o  out  1  pipeline stall request.
- illegal_o  out  1  one-cycle pulse: unknown funct decoded.

Function
REQ-005 Decode SHALL be:
- ALUOp 11 -> add (0001).
- ALUOp 01 -> sub (0010).
- ALUOp 00 -> add (0001).
- ALUOp 10, funct 0000000000 -> add (0001).
- ALUOp 10, funct 0100000000 -> sub (0010).
- ALUOp 10, funct 0000000111 -> and (0011).
- ALUOp 10, funct 0000000110 -> or (0100).
- ALUOp 10, funct 0000001000 -> mul (0110).
- ALUOp 10, funct 1000000111 -> relu (0111).
- ALUOp 10, funct 1100000111 -> maxpool (1000).
- ALUOp 10, funct 1110000111 -> fc (1001).
REQ-006 Any other funct under ALUOp 10, and the relu/maxpool/fc encodings when EXT_EN=0, SHALL decode to add (0001) and pulse illegal_o in the issue cycle.
REQ-007 A request SHALL be accepted at a rising edge k where valid_i=1, ready_o=1 and flush_i=0.
REQ-008 In the cycle after acceptance (k+1), ALUCtrl_o SHALL hold the decoded code and start_o SHALL be 1 for exactly one cycle.
REQ-009 Single-cycle ops (add, sub, and, or, illegal) SHALL assert done_o at k+1 and keep ready_o=1, so back-to-back issue every cycle is possible.
REQ-010 Multi-cycle ops SHALL use latency L = LAT_MUL for mul and L = LAT_CNN for relu/maxpool/fc.
REQ-011 For a multi-cycle op, the FSM SHALL go IDLE -> BUSY at edge k and load a down-counter with L-1.
REQ-012 In BUSY: busy_o=1, ready_o=0, and ALUCtrl_o is held constant.
REQ-013 The counter SHALL decrement once per cycle; when it reaches 0 (cycle k+L), done_o=1, ready_o=1 and the FSM returns to IDLE.
REQ-014 A new request SHALL be acceptable in the done cycle k+L (zero-bubble chaining).
REQ-015 stall_o SHALL equal valid_i AND NOT ready_o.
REQ-016 flush_i=1 SHALL force the FSM to IDLE at the next edge with no done_o, and set ALUCtrl_o to 0001.
REQ-017 If flush_i and valid_i are both 1 in the same cycle, flush SHALL win and the request SHALL NOT be accepted.
REQ-018 While IDLE with no accept, ALUCtrl_o SHALL retain its last value and start_o/done_o SHALL be 0.
REQ-019 Out-of-range LAT_MUL or LAT_CNN SHALL cause an elaboration-time error.

Reset
REQ-020 While rst_n_i=0 the block SHALL asynchronously force: FSM = IDLE, counter = 0, ALUCtrl_o = 0001, and start_o, busy_o, done_o, illegal_o, stall_o = 0.
REQ-021 ready_o SHALL be 1 in the first cycle after reset release.
REQ-022 Reset asserted during BUSY SHALL abort the operation with no done_o.

Structure
REQ-023 Package alu_ctrl_pkg SHALL hold the 4-bit control code constants, the ALUOp encodings, the funct constants and the FSM state type.
REQ-024 Combinational decode SHALL live in sub-module alu_ctrl_dec (inputs funct, ALUOp, EXT_EN; outputs code, is_multi, illegal); the FSM, counter and output registers live in alu_ctrl_seq.

Verification
REQ-025 Reset then ALUOp=10, funct=0100000000, valid 1 cycle -> next cycle ALUCtrl_o=0010, start_o=1, done_o=1, ready_o=1.
REQ-026 Defaults; mul (funct=0000001000) issued at edge k -> busy_o=1 for k+1..k+2, done_o at k+3, ready_o=0 at k+1..k+2; a valid_i during that window -> stall_o=1.
REQ-027 fc issued, then maxpool held valid -> maxpool accepted in the fc done cycle (k+4), ALUCtrl_o=1000 at k+5, no bubble.
REQ-028 EXT_EN=0, relu funct issued -> ALUCtrl_o=0001, illegal_o=1, done_o=1 after 1 cycle.
REQ-029 mul in flight, flush_i=1 together with valid_i=1 -> IDLE next edge, ALUCtrl_o=0001, no done_o, request not accepted.
REQ-030 rst_n_i pulsed low mid-BUSY -> all outputs at reset values immediately (asynchronously), ready_o=1 after release.
